// File: rtl/jtframe_mouse_emu.sv
// jtframe_mouse_emu
//  Per-player mouse front end. Real PS/2-style packets are routed to player 1 or 2
//  by mouse_idx, their 9-bit deltas are saturated to 8 bits and the three buttons
//  are extracted. When a player's joystick is held, a periodic tick synthesises
//  mouse motion from the directions so cores expecting a trackball stay playable.
//
//  Parameters
//    JOY_STEP    signed delta magnitude (1..127) applied per emulation tick per axis
//    EMU_PERIOD  clk cycles between emulation ticks (>=2)
//
//  Ports
//    clk        system clock
//    rst        asynchronous active-high reset
//    lock       forces every output (and emulation state) to zero while high
//    joy1/joy2  player directions, active-high: [3]up [2]down [1]left [0]right
//    mouse_dx   signed 9-bit X delta (right positive)
//    mouse_dy   signed 9-bit Y delta (up positive)
//    mouse_f    packet flags: [0]left [1]right [2]middle button
//    mouse_st   one-cycle strobe, packet valid on dx/dy/f/idx
//    mouse_idx  packet owner: 0=1P, 1=2P
//    mouse_1p   1P motion {dy[7:0], dx[7:0]}, two's complement, registered
//    mouse_2p   2P motion, same format
//    but_1p     1P buttons {middle,right,left}, registered
//    but_2p     2P buttons, same format
module jtframe_mouse_emu #(
  parameter int JOY_STEP   = 8,
  parameter int EMU_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lock,
  input  logic [3:0]  joy1,
  input  logic [3:0]  joy2,
  input  logic [8:0]  mouse_dx,
  input  logic [8:0]  mouse_dy,
  input  logic [7:0]  mouse_f,
  input  logic        mouse_st,
  input  logic        mouse_idx,
  output logic [15:0] mouse_1p,
  output logic [15:0] mouse_2p,
  output logic [2:0]  but_1p,
  output logic [2:0]  but_2p
);

  localparam int                CNT_W    = $clog2(EMU_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EMU_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]        STEP_POS = 8'(JOY_STEP);
  localparam logic [7:0]        STEP_NEG = 8'(-JOY_STEP);
  localparam logic signed [8:0] SAT_HI   = 9'sd127;
  localparam logic signed [8:0] SAT_LO   = -9'sd128;

  // Clamp a 9-bit signed delta into the 8-bit signed range.
  function automatic logic [7:0] sat8(input logic signed [8:0] v);
    logic [7:0] r;
    if (v > SAT_HI) begin
      r = 8'h7F;
    end else if (v < SAT_LO) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  // One emulated axis: a single pressed direction moves, none or both cancel out.
  function automatic logic [7:0] emu_axis(input logic pos, input logic neg);
    logic [7:0] r;
    case ({pos, neg})
      2'b10:   r = STEP_POS;
      2'b01:   r = STEP_NEG;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  logic [3:0]  joy_s      [2];
  logic [15:0] mouse_r    [2];
  logic [15:0] mouse_nx_s [2];
  logic [2:0]  but_r      [2];
  logic [2:0]  but_nx_s   [2];
  logic        emu_r      [2];
  logic        emu_nx_s   [2];
  logic [15:0] pkt_val_s;

  assign joy_s[0]  = joy1;
  assign joy_s[1]  = joy2;
  assign tick_s    = (cnt_r == CNT_LAST);
  assign pkt_val_s = {sat8(mouse_dy), sat8(mouse_dx)};

  // Free-running tick counter; it keeps counting while locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Next-state selection per player: lock > real packet > emulation tick > hold.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      mouse_nx_s[p] = mouse_r[p];
      but_nx_s[p]   = but_r[p];
      emu_nx_s[p]   = emu_r[p];
      if (lock) begin
        mouse_nx_s[p] = 16'h0000;
        but_nx_s[p]   = 3'b000;
        emu_nx_s[p]   = 1'b0;
      end else if (mouse_st && (mouse_idx == 1'(p))) begin
        mouse_nx_s[p] = pkt_val_s;
        but_nx_s[p]   = mouse_f[2:0];
        emu_nx_s[p]   = 1'b0;
      end else if (tick_s) begin
        if (joy_s[p] != 4'h0) begin
          mouse_nx_s[p] = {emu_axis(joy_s[p][3], joy_s[p][2]),
                           emu_axis(joy_s[p][0], joy_s[p][1])};
          emu_nx_s[p]   = 1'b1;
        end else if (emu_r[p]) begin
          // Emulated motion stops once the stick is released.
          mouse_nx_s[p] = 16'h0000;
          emu_nx_s[p]   = 1'b0;
        end else begin
          // Real mouse data is left untouched by an idle joystick.
          mouse_nx_s[p] = mouse_r[p];
          emu_nx_s[p]   = emu_r[p];
        end
      end else begin
        mouse_nx_s[p] = mouse_r[p];
        but_nx_s[p]   = but_r[p];
        emu_nx_s[p]   = emu_r[p];
      end
    end
  end

  // Player state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        mouse_r[p] <= 16'h0000;
        but_r[p]   <= 3'b000;
        emu_r[p]   <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        mouse_r[p] <= mouse_nx_s[p];
        but_r[p]   <= but_nx_s[p];
        emu_r[p]   <= emu_nx_s[p];
      end
    end
  end

  assign mouse_1p = mouse_r[0];
  assign mouse_2p = mouse_r[1];
  assign but_1p   = but_r[0];
  assign but_2p   = but_r[1];

endmodule

// File: tb/tb_jtframe_mouse_emu.sv
// tb_jtframe_mouse_emu
//  Directed table of one-cycle vectors with hand-computed expected outputs, built
//  with EMU_PERIOD=4 so that vector n lands on a tick when n%4==3 (the counter
//  starts at 0 on the first edge after reset release). A hand-written sequence
//  then covers asynchronous reset mid-operation and counter restart.
module tb_jtframe_mouse_emu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic [3:0]  joy1, joy2;
  logic [8:0]  mouse_dx, mouse_dy;
  logic [7:0]  mouse_f;
  logic        mouse_st, mouse_idx;
  logic [15:0] mouse_1p, mouse_2p;
  logic [2:0]  but_1p, but_2p;

  int errors = 0;
  int checks = 0;

  jtframe_mouse_emu #(.JOY_STEP(8), .EMU_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .lock(lock), .joy1(joy1), .joy2(joy2),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_f(mouse_f),
    .mouse_st(mouse_st), .mouse_idx(mouse_idx),
    .mouse_1p(mouse_1p), .mouse_2p(mouse_2p), .but_1p(but_1p), .but_2p(but_2p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lock;
    logic [3:0]  j1, j2;
    logic        st, idx;
    logic [8:0]  dx, dy;
    logic [7:0]  f;
    logic [15:0] e1, e2;
    logic [2:0]  b1, b2;
  } vec_t;

  localparam int NV = 36;
  vec_t vt[NV];

  function automatic vec_t mk(input logic lk, input logic [3:0] j1, input logic [3:0] j2,
                              input logic st, input logic idx, input logic [8:0] dx,
                              input logic [8:0] dy, input logic [7:0] f,
                              input logic [15:0] e1, input logic [15:0] e2,
                              input logic [2:0] b1, input logic [2:0] b2);
    vec_t v;
    v.lock = lk; v.j1 = j1; v.j2 = j2; v.st = st; v.idx = idx;
    v.dx = dx; v.dy = dy; v.f = f; v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                         input logic [2:0] b1, input logic [2:0] b2);
    chk({tag, " mouse_1p"}, mouse_1p, e1);
    chk({tag, " mouse_2p"}, mouse_2p, e2);
    chk({tag, " but_1p"}, {13'd0, but_1p}, {13'd0, b1});
    chk({tag, " but_2p"}, {13'd0, but_2p}, {13'd0, b2});
  endtask

  task automatic drive_idle();
    lock = 1'b0; joy1 = 4'h0; joy2 = 4'h0; mouse_st = 1'b0; mouse_idx = 1'b0;
    mouse_dx = 9'h000; mouse_dy = 9'h000; mouse_f = 8'h00;
  endtask

  initial begin
    //            lk  j1    j2    st  idx dx      dy      f       mouse_1p  mouse_2p  b1  b2
    vt[0]  = mk(0, 4'h0, 4'h0, 1, 0, 9'h005, 9'h1FD, 8'h05, 16'hFD05, 16'h0000, 3'd5, 3'd0);
    vt[1]  = mk(0, 4'h0, 4'h0, 1, 1, 9'h0C8, 9'h100, 8'h00, 16'hFD05, 16'h807F, 3'd5, 3'd0);
    vt[2]  = mk(0, 4'h0, 4'h0, 1, 1, 9'h138, 9'h07F, 8'hFA, 16'hFD05, 16'h7F80, 3'd5, 3'd2);
    vt[3]  = mk(0, 4'h9, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0808, 16'h7F80, 3'd5, 3'd2);
    vt[4]  = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0808, 16'h7F80, 3'd5, 3'd2);
    vt[5]  = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0808, 16'h7F80, 3'd5, 3'd2);
    vt[6]  = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0808, 16'h7F80, 3'd5, 3'd2);
    vt[7]  = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h7F80, 3'd5, 3'd2);
    vt[8]  = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h7F80, 3'd5, 3'd2);
    vt[9]  = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h7F80, 3'd5, 3'd2);
    vt[10] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h7F80, 3'd5, 3'd2);
    vt[11] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h7F80, 3'd5, 3'd2);
    vt[12] = mk(0, 4'h0, 4'h3, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h7F80, 3'd5, 3'd2);
    vt[13] = mk(0, 4'h0, 4'h3, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h7F80, 3'd5, 3'd2);
    vt[14] = mk(0, 4'h0, 4'h3, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h7F80, 3'd5, 3'd2);
    vt[15] = mk(0, 4'h6, 4'h3, 0, 0, 9'h000, 9'h000, 8'h00, 16'hF8F8, 16'h0000, 3'd5, 3'd2);
    vt[16] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'hF8F8, 16'h0000, 3'd5, 3'd2);
    vt[17] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'hF8F8, 16'h0000, 3'd5, 3'd2);
    vt[18] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'hF8F8, 16'h0000, 3'd5, 3'd2);
    vt[19] = mk(0, 4'hD, 4'h6, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0008, 16'hF8F8, 3'd5, 3'd2);
    vt[20] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0008, 16'hF8F8, 3'd5, 3'd2);
    vt[21] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0008, 16'hF8F8, 3'd5, 3'd2);
    vt[22] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0008, 16'hF8F8, 3'd5, 3'd2);
    vt[23] = mk(0, 4'h9, 4'h0, 1, 0, 9'h003, 9'h004, 8'h01, 16'h0403, 16'h0000, 3'd1, 3'd2);
    vt[24] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0403, 16'h0000, 3'd1, 3'd2);
    vt[25] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0403, 16'h0000, 3'd1, 3'd2);
    vt[26] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0403, 16'h0000, 3'd1, 3'd2);
    vt[27] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0403, 16'h0000, 3'd1, 3'd2);
    vt[28] = mk(1, 4'hF, 4'hF, 1, 0, 9'h001, 9'h001, 8'h07, 16'h0000, 16'h0000, 3'd0, 3'd0);
    vt[29] = mk(1, 4'hF, 4'h1, 1, 1, 9'h001, 9'h001, 8'h07, 16'h0000, 16'h0000, 3'd0, 3'd0);
    vt[30] = mk(1, 4'h1, 4'h1, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h0000, 3'd0, 3'd0);
    vt[31] = mk(1, 4'h1, 4'h1, 1, 0, 9'h002, 9'h002, 8'h03, 16'h0000, 16'h0000, 3'd0, 3'd0);
    vt[32] = mk(0, 4'h0, 4'h0, 1, 1, 9'h1FF, 9'h002, 8'h04, 16'h0000, 16'h02FF, 3'd0, 3'd4);
    vt[33] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h02FF, 3'd0, 3'd4);
    vt[34] = mk(0, 4'h0, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h0000, 16'h02FF, 3'd0, 3'd4);
    vt[35] = mk(0, 4'h2, 4'h0, 0, 0, 9'h000, 9'h000, 8'h00, 16'h00F8, 16'h02FF, 3'd0, 3'd4);

    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    chk_all("reset", 16'h0000, 16'h0000, 3'd0, 3'd0);
    rst = 1'b0;

    // Vector n is driven at a negedge, sampled 1 time unit after the next posedge.
    for (int n = 0; n < NV; n++) begin
      lock = vt[n].lock; joy1 = vt[n].j1; joy2 = vt[n].j2;
      mouse_st = vt[n].st; mouse_idx = vt[n].idx;
      mouse_dx = vt[n].dx; mouse_dy = vt[n].dy; mouse_f = vt[n].f;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", n), vt[n].e1, vt[n].e2, vt[n].b1, vt[n].b2);
      @(negedge clk);
    end

    // Asynchronous reset between edges clears outputs without waiting for clk.
    drive_idle();
    joy1 = 4'h1;
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h0000, 16'h0000, 3'd0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    // Counter restarts at 0: the tick arrives on the 4th edge after release.
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("restart e%0d mouse_1p", e), mouse_1p, (e == 3) ? 16'h0008 : 16'h0000);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
